// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// integer/FP bank bases and the architectural register address type.
package regfile_pkg;

    localparam int DATA_W_DEF   = 64;
    localparam int NUM_REGS_DEF = 64;

    // Integer registers occupy the low half, FP registers the high half.
    localparam int XREG_BASE = 0;
    localparam int FREG_BASE = 32;

    typedef logic [5:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: set on issue, cleared on writeback, with a
// combinational busy lookup for every read port.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS  = NUM_REGS_DEF,
    parameter int ADDR_W    = $clog2(NUM_REGS),
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 2,
    parameter int NUM_ALLOC = 1,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_WR-1:0]           wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]    wr_addr,
    input  logic [NUM_ALLOC-1:0]        alloc_en,
    input  logic [NUM_ALLOC*ADDR_W-1:0] alloc_addr,
    input  logic [NUM_RD*ADDR_W-1:0]    rd_addr,
    output logic [NUM_RD-1:0]           rd_busy,
    output logic [NUM_REGS-1:0]         busy_vec
);

    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] busy_next;

    genvar gi;

    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic alloc_hit;
            logic wr_hit;

            always_comb begin
                alloc_hit = 1'b0;
                wr_hit    = 1'b0;
                for (int k = 0; k < NUM_ALLOC; k++) begin
                    if (alloc_en[k] && alloc_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(gi)) begin
                        alloc_hit = 1'b1;
                    end
                end
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(gi)) begin
                        wr_hit = 1'b1;
                    end
                end
            end

            // A new producer issued in the same cycle outranks the retiring one.
            assign busy_next[gi] = (ZERO_REG != 0 && gi == 0) ? 1'b0
                                 : (alloc_hit | (busy_reg[gi] & ~wr_hit));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy_vec = busy_reg;

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic              in_range;
            logic              busy;

            assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

            if (NUM_REGS == (1 << ADDR_W)) begin : g_full
                assign in_range = 1'b1;
            end else begin : g_part
                assign in_range = 32'(addr) < 32'(NUM_REGS);
            end

            // With forwarding, a retiring write hands the data over, so no stall.
            always_comb begin
                busy = 1'b0;
                if (in_range) begin
                    busy = busy_reg[addr];
                end
                if (BYPASS != 0) begin
                    for (int j = 0; j < NUM_WR; j++) begin
                        if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == addr) begin
                            busy = 1'b0;
                        end
                    end
                end
            end

            assign rd_busy[gi] = busy;
        end
    endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional write-to-read bypass
// and an issue/writeback busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int NUM_REGS  = NUM_REGS_DEF,
    parameter int ADDR_W    = $clog2(NUM_REGS),
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 2,
    parameter int NUM_ALLOC = 1,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]    rd_addr,
    output logic [NUM_RD*DATA_W-1:0]    rd_data,
    output logic [NUM_RD-1:0]           rd_busy,
    input  logic [NUM_WR-1:0]           wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]    wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]    wr_data,
    input  logic [NUM_ALLOC-1:0]        alloc_en,
    input  logic [NUM_ALLOC*ADDR_W-1:0] alloc_addr,
    output logic [NUM_REGS-1:0]         busy_vec
);

    logic [DATA_W-1:0] mem_reg [NUM_REGS];

    genvar gi;

    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic              hit;
            logic [DATA_W-1:0] wdata;

            // Later ports overwrite earlier ones, so the highest port wins.
            always_comb begin
                hit   = 1'b0;
                wdata = mem_reg[gi];
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(gi)) begin
                        hit   = 1'b1;
                        wdata = wr_data[j*DATA_W +: DATA_W];
                    end
                end
                if (ZERO_REG != 0 && gi == 0) begin
                    hit = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    mem_reg[gi] <= '0;
                end else if (hit) begin
                    mem_reg[gi] <= wdata;
                end
            end
        end

        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic              in_range;
            logic [DATA_W-1:0] data;

            assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

            if (NUM_REGS == (1 << ADDR_W)) begin : g_full
                assign in_range = 1'b1;
            end else begin : g_part
                assign in_range = 32'(addr) < 32'(NUM_REGS);
            end

            always_comb begin
                data = '0;
                if (in_range) begin
                    data = mem_reg[addr];
                end
                if (BYPASS != 0 && in_range) begin
                    for (int j = 0; j < NUM_WR; j++) begin
                        if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == addr) begin
                            data = wr_data[j*DATA_W +: DATA_W];
                        end
                    end
                end
                // The hardwired zero overrides any forwarded value.
                if (ZERO_REG != 0 && addr == '0) begin
                    data = '0;
                end
            end

            assign rd_data[gi*DATA_W +: DATA_W] = data;
        end
    endgenerate

    regfile_scoreboard #(
        .NUM_REGS  (NUM_REGS),
        .ADDR_W    (ADDR_W),
        .NUM_RD    (NUM_RD),
        .NUM_WR    (NUM_WR),
        .NUM_ALLOC (NUM_ALLOC),
        .ZERO_REG  (ZERO_REG),
        .BYPASS    (BYPASS)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .rd_addr    (rd_addr),
        .rd_busy    (rd_busy),
        .busy_vec   (busy_vec)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance
// share stimulus; a vector table plus a multi-cycle scoreboard sequence.
module tb_regfile_mp;
    import regfile_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [11:0]   rd_addr;
    logic [127:0]  rd_data_b, rd_data_n;
    logic [1:0]    rd_busy_b, rd_busy_n;
    logic [1:0]    wr_en;
    logic [11:0]   wr_addr;
    logic [127:0]  wr_data;
    logic [0:0]    alloc_en;
    logic [5:0]    alloc_addr;
    logic [63:0]   busy_vec_b, busy_vec_n;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_mp #(.BYPASS(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_vec(busy_vec_b)
    );

    regfile_mp #(.BYPASS(0)) u_dut_n (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n),
        .rd_busy(rd_busy_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_vec(busy_vec_n)
    );

    typedef struct {
        logic        chk;
        logic        rst_n;
        logic [1:0]  we;
        reg_addr_t   wa0;
        logic [63:0] wd0;
        reg_addr_t   wa1;
        logic [63:0] wd1;
        logic        ae;
        reg_addr_t   aa;
        reg_addr_t   ra0;
        reg_addr_t   ra1;
        logic [63:0] b0, b1;
        logic [1:0]  brb;
        logic [63:0] n0, n1;
        logic [1:0]  nrb;
        logic [63:0] busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(logic chk, logic rst, logic [1:0] we,
                                 reg_addr_t wa0, logic [63:0] wd0,
                                 reg_addr_t wa1, logic [63:0] wd1,
                                 logic ae, reg_addr_t aa, reg_addr_t ra0, reg_addr_t ra1,
                                 logic [63:0] b0, logic [63:0] b1, logic [1:0] brb,
                                 logic [63:0] n0, logic [63:0] n1, logic [1:0] nrb,
                                 logic [63:0] busy);
        vec_t v;
        v.chk = chk; v.rst_n = rst; v.we = we;
        v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.ae = ae; v.aa = aa; v.ra0 = ra0; v.ra1 = ra1;
        v.b0 = b0; v.b1 = b1; v.brb = brb;
        v.n0 = n0; v.n1 = n1; v.nrb = nrb; v.busy = busy;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic idle();
        rst_n      = 1'b1;
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        alloc_en   = '0;
        alloc_addr = '0;
        rd_addr    = '0;
    endtask

    initial begin
        //            chk rst we    wa0 wd0                    wa1 wd1       ae aa  ra0 ra1  b0       b1       brb    n0       n1       nrb    busy
        vecs.push_back(mkv(0, 0, 2'b00, 0, 64'h0,                  0, 64'h0,     0, 0,  0,  0,  64'h0,   64'h0,   2'b00, 64'h0,   64'h0,   2'b00, 64'h0));
        vecs.push_back(mkv(1, 1, 2'b01, 5, 64'hDEAD,               0, 64'h0,     0, 0,  5,  0,  64'hDEAD,64'h0,   2'b00, 64'h0,   64'h0,   2'b00, 64'h0));
        vecs.push_back(mkv(1, 1, 2'b00, 0, 64'h0,                  0, 64'h0,     0, 0,  5,  5,  64'hDEAD,64'hDEAD,2'b00, 64'hDEAD,64'hDEAD,2'b00, 64'h0));
        vecs.push_back(mkv(1, 0, 2'b11, 9, 64'h55,                 5, 64'hBEEF,  1, 3,  9,  5,  64'h55,  64'hBEEF,2'b00, 64'h0,   64'hDEAD,2'b00, 64'h0));
        vecs.push_back(mkv(1, 0, 2'b11, 9, 64'h55,                 5, 64'hBEEF,  1, 3,  9,  5,  64'h55,  64'hBEEF,2'b00, 64'h0,   64'h0,   2'b00, 64'h0));
        vecs.push_back(mkv(1, 1, 2'b00, 0, 64'h0,                  0, 64'h0,     0, 0,  9,  5,  64'h0,   64'h0,   2'b00, 64'h0,   64'h0,   2'b00, 64'h0));
        vecs.push_back(mkv(1, 1, 2'b01, 0, 64'hFFFF_FFFF_FFFF_FFFF,0, 64'h0,     1, 0,  0,  0,  64'h0,   64'h0,   2'b00, 64'h0,   64'h0,   2'b00, 64'h0));
        vecs.push_back(mkv(1, 1, 2'b00, 0, 64'h0,                  0, 64'h0,     0, 0,  0,  0,  64'h0,   64'h0,   2'b00, 64'h0,   64'h0,   2'b00, 64'h0));
        vecs.push_back(mkv(1, 1, 2'b01, 7, 64'h1234,               0, 64'h0,     0, 0,  5,  7,  64'h0,   64'h1234,2'b00, 64'h0,   64'h0,   2'b00, 64'h0));
        vecs.push_back(mkv(1, 1, 2'b00, 0, 64'h0,                  0, 64'h0,     0, 0,  5,  7,  64'h0,   64'h1234,2'b00, 64'h0,   64'h1234,2'b00, 64'h0));
        vecs.push_back(mkv(1, 1, 2'b11, 33,64'hAAAA,               33,64'hBBBB,  0, 0,  33, 7,  64'hBBBB,64'h1234,2'b00, 64'h0,   64'h1234,2'b00, 64'h0));
        vecs.push_back(mkv(1, 1, 2'b00, 0, 64'h0,                  0, 64'h0,     0, 0,  33, 33, 64'hBBBB,64'hBBBB,2'b00, 64'hBBBB,64'hBBBB,2'b00, 64'h0));
        vecs.push_back(mkv(1, 1, 2'b00, 0, 64'h0,                  0, 64'h0,     1, 10, 10, 33, 64'h0,   64'hBBBB,2'b00, 64'h0,   64'hBBBB,2'b00, 64'h0));
        vecs.push_back(mkv(1, 1, 2'b00, 0, 64'h0,                  0, 64'h0,     0, 0,  10, 11, 64'h0,   64'h0,   2'b01, 64'h0,   64'h0,   2'b01, 64'h400));
        vecs.push_back(mkv(1, 1, 2'b01, 10,64'h77,                 0, 64'h0,     0, 0,  10, 10, 64'h77,  64'h77,  2'b00, 64'h0,   64'h0,   2'b11, 64'h400));
        vecs.push_back(mkv(1, 1, 2'b00, 0, 64'h0,                  0, 64'h0,     0, 0,  10, 10, 64'h77,  64'h77,  2'b00, 64'h77,  64'h77,  2'b00, 64'h0));
        vecs.push_back(mkv(1, 1, 2'b00, 0, 64'h0,                  0, 64'h0,     1, 12, 12, 12, 64'h0,   64'h0,   2'b00, 64'h0,   64'h0,   2'b00, 64'h0));
        vecs.push_back(mkv(1, 1, 2'b10, 0, 64'h0,                  12,64'hC0DE,  1, 12, 12, 10, 64'hC0DE,64'h77,  2'b00, 64'h0,   64'h77,  2'b01, 64'h1000));
        vecs.push_back(mkv(1, 1, 2'b00, 0, 64'h0,                  0, 64'h0,     0, 0,  12, 12, 64'hC0DE,64'hC0DE,2'b11, 64'hC0DE,64'hC0DE,2'b11, 64'h1000));
        vecs.push_back(mkv(1, 1, 2'b11, 12,64'h1,                  40,64'h4040,  0, 0,  12, 40, 64'h1,   64'h4040,2'b00, 64'hC0DE,64'h0,   2'b01, 64'h1000));
        vecs.push_back(mkv(1, 1, 2'b00, 0, 64'h0,                  0, 64'h0,     0, 0,  12, 40, 64'h1,   64'h4040,2'b00, 64'h1,   64'h4040,2'b00, 64'h0));
        vecs.push_back(mkv(1, 1, 2'b00, 0, 64'h0,                  0, 64'h0,     1, 20, 20, 20, 64'h0,   64'h0,   2'b00, 64'h0,   64'h0,   2'b00, 64'h0));
        vecs.push_back(mkv(1, 0, 2'b00, 0, 64'h0,                  0, 64'h0,     0, 0,  20, 20, 64'h0,   64'h0,   2'b11, 64'h0,   64'h0,   2'b11, 64'h100000));
        vecs.push_back(mkv(1, 1, 2'b00, 0, 64'h0,                  0, 64'h0,     0, 0,  20, 20, 64'h0,   64'h0,   2'b00, 64'h0,   64'h0,   2'b00, 64'h0));

        idle();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n      = vecs[i].rst_n;
            wr_en      = vecs[i].we;
            wr_addr    = {vecs[i].wa1, vecs[i].wa0};
            wr_data    = {vecs[i].wd1, vecs[i].wd0};
            alloc_en   = vecs[i].ae;
            alloc_addr = vecs[i].aa;
            rd_addr    = {vecs[i].ra1, vecs[i].ra0};
            #2;
            if (vecs[i].chk) begin
                check("rd_data0_byp",   i, rd_data_b[63:0],   vecs[i].b0);
                check("rd_data1_byp",   i, rd_data_b[127:64], vecs[i].b1);
                check("rd_busy_byp",    i, 64'(rd_busy_b),    64'(vecs[i].brb));
                check("rd_data0_nobyp", i, rd_data_n[63:0],   vecs[i].n0);
                check("rd_data1_nobyp", i, rd_data_n[127:64], vecs[i].n1);
                check("rd_busy_nobyp",  i, 64'(rd_busy_n),    64'(vecs[i].nrb));
                check("busy_vec_byp",   i, busy_vec_b,        vecs[i].busy);
                check("busy_vec_nobyp", i, busy_vec_n,        vecs[i].busy);
            end
        end

        // Busy must persist across idle cycles until a port-1 writeback retires it.
        @(negedge clk);
        idle();
        alloc_en   = 1'b1;
        alloc_addr = 6'd50;
        rd_addr    = {6'd0, 6'd50};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            idle();
            rd_addr = {6'd0, 6'd50};
            #2;
            check("hold_busy_vec", k, 64'(busy_vec_b[50]), 64'h1);
            check("hold_rd_busy",  k, 64'(rd_busy_n[0]),   64'h1);
        end
        @(negedge clk);
        wr_en   = 2'b10;
        wr_addr = {6'd50, 6'd0};
        wr_data = {64'h5050, 64'h0};
        #2;
        check("retire_rd_busy_byp",   0, 64'(rd_busy_b[0]), 64'h0);
        check("retire_rd_busy_nobyp", 0, 64'(rd_busy_n[0]), 64'h1);
        check("retire_rd_data_byp",   0, rd_data_b[63:0],   64'h5050);
        @(negedge clk);
        idle();
        rd_addr = {6'd0, 6'd50};
        #2;
        check("retired_busy_vec_byp",   0, busy_vec_b,      64'h0);
        check("retired_busy_vec_nobyp", 0, busy_vec_n,      64'h0);
        check("retired_rd_data_nobyp",  0, rd_data_n[63:0], 64'h5050);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; successor to the 2R/1W integer+FP file.
- Configurable read/write port counts, depth and width.
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard (set at issue, cleared at writeback) so decode can stall on pending producers.
- Sits between decode/issue (read + alloc) and the writeback stage (write).

Parameters:
DATA_W, 64, register width in bits
NUM_REGS, 64, register count (0..31 = x0..x31, 32..63 = f0..f31 in default config)
ADDR_W, $clog2(NUM_REGS), address width (derived, not overridden)
NUM_RD, 2, read ports
NUM_WR, 2, write ports
NUM_ALLOC, 1, busy-set (issue) ports
ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy
BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous reset, active-low
rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, combinational
rd_busy  out  NUM_RD  1 = addressed register has a pending producer
wr_en  in  NUM_WR  write strobes
wr_addr  in  NUM_WR*ADDR_W  write addresses
wr_data  in  NUM_WR*DATA_W  write data
alloc_en  in  NUM_ALLOC  mark destination busy
alloc_addr  in  NUM_ALLOC*ADDR_W  destinations to mark busy
busy_vec  out  NUM_REGS  registered scoreboard, bit r = register r busy

Behaviour:
- Reset: clk is the only clock. rst_n is synchronous and active-low. On a rising edge with rst_n=0, every register and every busy bit is cleared to 0. Reset wins over all writes and allocs in that cycle.
- Reset outputs: busy_vec=0 on the edge after reset. rd_data and rd_busy are combinational from the cleared state, so 0 unless bypassed.
- Write: on each edge with rst_n=1, for each port j with wr_en[j] set, reg[wr_addr_j] <= wr_data_j. Latency is 1 cycle to the array.
- Write conflict: if several ports target the same address, the highest-numbered port wins (deterministic, no error flag).
- ZERO_REG=1, address 0:
  - writes to address 0 are dropped; reads of address 0 return 0 regardless of the bypass path;
  - alloc to address 0 is dropped; rd_busy for address 0 is always 0.
- Read, BYPASS=1: rd_data_i = data from the highest-numbered active write port whose wr_addr equals rd_addr_i, else reg[rd_addr_i]. This is a zero-cycle forward.
- Read, BYPASS=0: rd_data_i = reg[rd_addr_i]. A same-cycle write is visible next cycle.
- Scoreboard, next-state per register r:
  - alloc hit on r -> busy[r]=1;
  - else write hit on r -> busy[r]=0;
  - else hold.
  - Simultaneous alloc and write to the same r leaves it busy: the new producer supersedes the retiring one.
- rd_busy_i, BYPASS=1: busy[rd_addr_i] & ~(any wr_en hit on rd_addr_i). The data is forwarded, so no stall.
- rd_busy_i, BYPASS=0: busy[rd_addr_i].
- Same-cycle alloc does not affect rd_busy in that cycle.
- A write to a non-busy register is legal; data updates and busy stays 0.
- Address range: addresses >= NUM_REGS (non-power-of-two depth) are ignored on write and alloc; reads of them return 0 and not-busy.
- Reset mid-operation: pending busy bits are lost. Issue logic is flushed together with the file.

Decomposition:
- Shared package regfile_pkg holds:
  - defaults DATA_W_DEF=64, NUM_REGS_DEF=64;
  - constants XREG_BASE=0, FREG_BASE=32;
  - reg_addr_t typedef (6-bit).
- One natural sub-module: regfile_scoreboard, holding the busy_vec state, alloc/clear priority and the rd_busy lookup.
- Data array, write-conflict resolution and bypass muxing stay in regfile_mp.

Test Plan:
- Reset: rst_n=0 for 2 cycles after writing reg5=0xDEAD -> rd_data(5)=0, busy_vec=0. Hold rst_n=0 with wr_en set -> array stays 0.
- Zero register: write 0xFFFF_FFFF_FFFF_FFFF to addr 0 with rd_addr0=0 in the same cycle -> rd_data0=0 in that cycle and after. Alloc addr 0 -> busy_vec[0]=0.
- Bypass: BYPASS=1, wr0 addr 7 data 0x1234 with rd_addr1=7 in the same cycle -> rd_data1=0x1234 combinationally. Repeat with BYPASS=0 -> old value, then 0x1234 next cycle.
- Write conflict: wr0 and wr1 both to addr 33 with 0xAAAA and 0xBBBB -> reg33=0xBBBB, bypass also returns 0xBBBB.
- Scoreboard: alloc 10 -> busy_vec[10]=1 next cycle and rd_busy=1. Write 10 with rd_addr=10 in the same cycle -> rd_busy=0 that cycle (BYPASS=1), busy_vec[10]=0 next cycle.
- Alloc/write collision: alloc 12 and write 12 in the same cycle while busy -> busy_vec[12] stays 1 and reg12 takes the write data.
